// File: rtl/lsu_controller.sv
// rtl/lsu_controller.sv - load/store sequencer between memory stage and data-memory port
// Checks alignment, drives word-aligned byte-enabled transactions, extends load data.
module lsu_controller #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e              state_q;
  logic [7:0]          wait_q;
  logic [1:0]          size_q;
  logic [1:0]          off_q;
  logic                uns_q;
  logic                busy_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [31:0]         rsp_rdata_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [3:0]          mem_be_q;
  logic [31:0]         mem_wdata_q;

  logic                misaligned_d;
  logic [3:0]          be_d;
  logic [31:0]         wdata_d;
  logic [31:0]         shifted_d;
  logic [31:0]         load_d;

  always_comb begin
    misaligned_d = 1'b0;
    be_d         = 4'b1111;
    wdata_d      = req_wdata;
    case (req_size)
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned_d = req_addr[0];
        be_d         = 4'b0011 << req_addr[1:0];
        wdata_d      = {2{req_wdata[15:0]}};
      end
      2'b10: misaligned_d = (req_addr[1:0] != 2'b00);
      default: misaligned_d = 1'b1;
    endcase
    // Loads always fetch the whole word; lane selection happens on the way back.
    if (!req_we) be_d = 4'b1111;
  end

  always_comb begin
    shifted_d = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_d = {{24{~uns_q & shifted_d[7]}}, shifted_d[7:0]};
      2'b01:   load_d = {{16{~uns_q & shifted_d[15]}}, shifted_d[15:0]};
      default: load_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= 8'd0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
          if (req_valid) begin
            size_q <= req_size;
            off_q  <= req_addr[1:0];
            uns_q  <= req_unsigned;
            busy_q <= 1'b1;
            if (misaligned_d) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              wait_q      <= 8'd0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        S_REQ: begin
          // An ack arriving on the last allowed cycle still completes normally.
          if (mem_ack || (wait_q == 8'(MAX_WAIT - 1))) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~mem_ack;
            rsp_rdata_q <= (mem_ack && !mem_we_q) ? load_d : 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign req_ready = ~busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_controller.sv
// tb/tb_lsu_controller.sv - directed vector bench for lsu_controller
// Vector table for single accesses, hand sequences for reset and back-to-back.
module tb_lsu_controller;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  lsu_controller #(.ADDR_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;
    int          exp_nreq;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[16];
  int n_vec;
  int n_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   n_req;
    bit   got;
    v = vecs[i];
    @(negedge clk);
    check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    n_req = 0;
    got   = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (rsp_valid) begin
        got     = 1'b1;
        mem_ack = 1'b0;
        check($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d rsp_rdata", i), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d mem_req at rsp", i), 32'(mem_req), 32'd0);
        check($sformatf("v%0d busy at rsp", i), 32'(busy), 32'd1);
      end else begin
        if (mem_req) n_req++;
        if (k == 0 && v.exp_nreq > 0) begin
          check($sformatf("v%0d mem_addr", i), mem_addr, {v.addr[31:2], 2'b00});
          check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v.we));
          check($sformatf("v%0d mem_be", i), 32'(mem_be), 32'(v.exp_be));
          if (v.we) check($sformatf("v%0d mem_wdata", i), mem_wdata, v.exp_wdata);
        end
        if (v.ack_dly >= 0 && k == v.ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end else begin
          mem_ack = 1'b0;
        end
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    check($sformatf("v%0d rsp seen", i), 32'(got), 32'd1);
    check($sformatf("v%0d mem_req cycles", i), 32'(n_req), 32'(v.exp_nreq));
    @(negedge clk);
    check($sformatf("v%0d rsp_valid pulse", i), 32'(rsp_valid), 32'd0);
    check($sformatf("v%0d ready after", i), 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_b2b[3];
    logic [31:0] b2b_addr[3];
    int idx, nrsp, nacc, wcnt;
    bit acc_pending;

    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    //          we    size   uns   addr          wdata         rdata         dly nreq err  be       exp_wdata     exp_rdata
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0,  1, 1'b0, 4'b1111, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0,  1, 1'b0, 4'b1111, 32'h0,        32'h0000_0080};
    vecs[2]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0,        0,  1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'h0,        32'h0,        -1, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        -1, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0305, 32'h0,        32'h0,        -1, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0306, 32'h0,        32'h8001_7FFF, 2,  3, 1'b0, 4'b1111, 32'h0,        32'hFFFF_8001};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0306, 32'h0,        32'h8001_7FFF, 2,  3, 1'b0, 4'b1111, 32'h0,        32'h0000_8001};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00A5, 32'h0,        1,  2, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h0,        0,  1, 1'b0, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        32'hCAFE_BABE, 0,  1, 1'b0, 4'b1111, 32'h0,        32'hCAFE_BABE};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_0041, 32'h0,        32'h0000_7F00, 0,  1, 1'b0, 4'b1111, 32'h0,        32'h0000_007F};
    vecs[12] = '{1'b1, 2'b10, 1'b0, 32'h0000_0022, 32'h5555_5555, 32'h0,        -1, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h0000_0050, 32'h0,        32'h0,        -1, 15, 1'b1, 4'b1111, 32'h0,       32'h0};
    vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0050, 32'h0,        32'h1122_3344, 14, 15, 1'b0, 4'b1111, 32'h0,       32'h1122_3344};
    vecs[15] = '{1'b0, 2'b10, 1'b1, 32'h0000_0060, 32'h0,        32'h8000_0000, 0,  1, 1'b0, 4'b1111, 32'h0,        32'h8000_0000};

    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i);

    // Reset in the middle of a memory request abandons the access.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0100;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst mem_req", 32'(mem_req), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst req_ready", 32'(req_ready), 32'd1);
    check("mid rst mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post rst rsp_valid %0d", k), 32'(rsp_valid), 32'd0);
      check($sformatf("post rst req_ready %0d", k), 32'(req_ready), 32'd1);
    end
    mem_ack = 1'b0;

    // Back-to-back loads with req_valid held high and a 2-cycle memory wait.
    b2b_addr[0] = 32'h0000_1000; b2b_addr[1] = 32'h0000_2004; b2b_addr[2] = 32'h0000_3008;
    exp_b2b[0] = 32'h1000_5A5A;  exp_b2b[1] = 32'h2004_5A5A;  exp_b2b[2] = 32'h3008_5A5A;
    idx = 0; nrsp = 0; nacc = 0; wcnt = 0; acc_pending = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = b2b_addr[0];
    for (int cyc = 0; cyc < 100 && nrsp < 3; cyc++) begin
      if (acc_pending) begin
        acc_pending = 1'b0;
        idx++;
        if (idx < 3) req_addr = b2b_addr[idx];
        else req_valid = 1'b0;
      end
      if (rsp_valid) begin
        check($sformatf("b2b rsp_rdata %0d", nrsp), rsp_rdata, exp_b2b[nrsp]);
        check($sformatf("b2b rsp_err %0d", nrsp), 32'(rsp_err), 32'd0);
        nrsp++;
      end
      if (mem_req) begin
        if (wcnt == 2) begin
          mem_ack = 1'b1; mem_rdata = {mem_addr[15:0], 16'h5A5A}; wcnt = 0;
        end else begin
          mem_ack = 1'b0; wcnt++;
        end
      end else begin
        mem_ack = 1'b0; wcnt = 0;
      end
      if (req_ready && req_valid) begin
        acc_pending = 1'b1;
        nacc++;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    req_valid = 1'b0;
    check("b2b responses", 32'(nrsp), 32'd3);
    check("b2b accepts", 32'(nacc), 32'd3);
    @(negedge clk);
    check("b2b idle ready", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
